// File: rtl/stream_rr_multiplexer.sv
// N-to-1 round-robin valid/ready stream mux feeding one registered output stage; 1-cycle latency.
// Define LIBSTF_MUX_PACKET_LOCK_EN to hold the grant on one input until its i_last beat.
module stream_rr_multiplexer #(
   parameter int  N_STREAMS = 2,
   parameter type DATA_TYPE = logic [63:0],
   localparam int N_BITS    = (N_STREAMS > 1) ? $clog2(N_STREAMS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  DATA_TYPE             i_data [N_STREAMS],
   input  logic [N_STREAMS-1:0] i_last,
   input  logic [N_STREAMS-1:0] i_valid,
   output logic [N_STREAMS-1:0] i_ready,
   output DATA_TYPE             o_data,
   output logic                 o_last,
   output logic [N_BITS-1:0]    o_select,
   output logic                 o_valid,
   input  logic                 o_ready
);

   logic                 o_valid_q, o_valid_d;
   logic                 o_last_q, o_last_d;
   logic [N_BITS-1:0]    o_select_q, o_select_d;
   DATA_TYPE             o_data_q, o_data_d;
   logic [N_BITS-1:0]    ptr_q, ptr_d;

   logic [N_STREAMS-1:0] eligible;
   logic [N_BITS-1:0]    grant, grant_hi, grant_lo, next_ptr;
   logic                 found_hi, found_lo;
   logic                 load, xfer, adv;

`ifdef LIBSTF_MUX_PACKET_LOCK_EN
   logic                 lock_q, lock_d;
   logic [N_BITS-1:0]    lock_id_q, lock_id_d;

   // While a packet is open only its source may compete.
   always_comb begin
      eligible = '0;
      if (lock_q) begin
         eligible[lock_id_q] = i_valid[lock_id_q];
      end else begin
         eligible = i_valid;
      end
   end

   always_comb begin
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      if (xfer) begin
         lock_d    = !i_last[grant];
         lock_id_d = grant;
      end
   end

   assign adv = i_last[grant];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   assign eligible = i_valid;
   assign adv      = 1'b1;
`endif

   // Lowest eligible index at or above ptr wins; otherwise wrap to the lowest overall.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      grant_hi = '0;
      grant_lo = '0;
      for (int k = N_STREAMS - 1; k >= 0; k--) begin
         if (eligible[k]) begin
            grant_lo = N_BITS'(k);
            found_lo = 1'b1;
            if (k >= int'(ptr_q)) begin
               grant_hi = N_BITS'(k);
               found_hi = 1'b1;
            end
         end
      end
      grant    = found_hi ? grant_hi : grant_lo;
      next_ptr = (int'(grant) == N_STREAMS - 1) ? '0 : grant + 1'b1;
   end

   assign load = !o_valid_q || o_ready;
   assign xfer = load && found_lo;

   always_comb begin
      i_ready = '0;
      if (xfer) begin
         i_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      o_valid_d  = o_valid_q;
      o_last_d   = o_last_q;
      o_select_d = o_select_q;
      o_data_d   = o_data_q;
      ptr_d      = ptr_q;
      if (load) begin
         o_valid_d = found_lo;
         if (found_lo) begin
            o_data_d   = i_data[grant];
            o_last_d   = i_last[grant];
            o_select_d = grant;
            if (adv) begin
               ptr_d = next_ptr;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_valid_q  <= 1'b0;
         o_last_q   <= 1'b0;
         o_select_q <= '0;
         ptr_q      <= '0;
      end else begin
         o_valid_q  <= o_valid_d;
         o_last_q   <= o_last_d;
         o_select_q <= o_select_d;
         ptr_q      <= ptr_d;
      end
   end

   // Payload is qualified by o_valid, so it needs no reset.
   always_ff @(posedge clk) begin
      o_data_q <= o_data_d;
   end

   assign o_data   = o_data_q;
   assign o_last   = o_last_q;
   assign o_select = o_select_q;
   assign o_valid  = o_valid_q;

endmodule

// File: tb/tb_stream_rr_multiplexer.sv
// Bench for stream_rr_multiplexer: directed boundary cases plus random traffic against
// a round-robin reference model and per-input scoreboard queues.
module tb_stream_rr_multiplexer;
   localparam int N = 4;

`ifdef LIBSTF_MUX_PACKET_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [63:0]   i_data [N];
   logic [N-1:0]  i_last, i_valid, i_ready;
   logic [63:0]   o_data;
   logic          o_last;
   logic [1:0]    o_select;
   logic          o_valid, o_ready;

   always #5 clk = ~clk;

   stream_rr_multiplexer #(.N_STREAMS(N)) dut (
      .clk(clk), .rst(rst),
      .i_data(i_data), .i_last(i_last), .i_valid(i_valid), .i_ready(i_ready),
      .o_data(o_data), .o_last(o_last), .o_select(o_select),
      .o_valid(o_valid), .o_ready(o_ready)
   );

   int           n_checks = 0, n_errors = 0, cyc = 0;
   bit           m_vld, m_lock;
   int           m_start, m_lock_id;
   logic [64:0]  sb [N][$];
   int           remain [N];
   bit           rand_mode, last_all;
   logic [N-1:0] en_mask;
   int           out_sel [$];
   logic [63:0]  out_dat [$];
   int           out_cyc [$];
   int           acc2_cyc [$];
   logic [63:0]  last_acc_dat;
   int           last_acc_k;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Round-robin choice: first requester found walking upward from m_start, wrapping.
   function automatic int rr_pick(input logic [N-1:0] v);
      logic [N-1:0] e;
      e = v;
      if (LOCK_EN && m_lock) e = v & (4'b0001 << m_lock_id);
      for (int j = 0; j < N; j++) begin
         int k;
         k = (m_start + j) % N;
         if (((e >> k) & 4'b0001) != 4'b0000) return k;
      end
      return -1;
   endfunction

   task automatic apply_src();
      for (int k = 0; k < N; k++) begin
         logic [1:0] kk;
         kk = 2'(k);
         i_valid[kk] = remain[k] > 0;
         i_last[kk]  = last_all || remain[k] == 1;
      end
   endtask

   task automatic tick();
      logic [N-1:0] acc, exp_rdy;
      logic [64:0]  ent;
      int           w;
      bit           ld, w_last;
      @(negedge clk);
      ld = !m_vld || o_ready;
      w  = rr_pick(i_valid);
      exp_rdy = '0;
      if (ld && w >= 0) exp_rdy = 4'b0001 << w;
      check("i_ready", 64'(i_ready), 64'(exp_rdy));
      check("o_valid", 64'(o_valid), 64'(m_vld));
      if (o_valid && o_ready) begin
         check("sb_has_beat", 64'(sb[o_select].size() > 0), 64'(1));
         if (sb[o_select].size() > 0) begin
            ent = sb[o_select].pop_front();
            check("o_data", o_data, ent[63:0]);
            check("o_last", 64'(o_last), 64'(ent[64]));
         end
         out_sel.push_back(int'(o_select));
         out_dat.push_back(o_data);
         out_cyc.push_back(cyc);
      end
      acc = i_valid & i_ready;
      for (int k = 0; k < N; k++) begin
         logic [1:0] kk;
         kk = 2'(k);
         if (acc[kk]) begin
            sb[kk].push_back({i_last[kk], i_data[kk]});
            last_acc_dat = i_data[kk];
            last_acc_k   = k;
            if (k == 2) acc2_cyc.push_back(cyc);
         end
      end
      if (ld) begin
         m_vld = (w >= 0);
         if (w >= 0) begin
            w_last = ((i_last >> w) & 4'b0001) != 4'b0000;
            if (LOCK_EN && !w_last) begin
               m_lock    = 1'b1;
               m_lock_id = w;
            end else begin
               m_lock  = 1'b0;
               m_start = (w + 1) % N;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      for (int k = 0; k < N; k++) begin
         logic [1:0] kk;
         kk = 2'(k);
         if (acc[kk]) begin
            i_data[kk] = i_data[kk] + 64'd1;
            if (remain[k] > 0) remain[k]--;
         end
         if (rand_mode) begin
            if (acc[kk] || !i_valid[kk]) begin
               i_valid[kk] = en_mask[kk] && ($urandom_range(0, 2) != 0);
               i_last[kk]  = $urandom_range(0, 3) == 0;
            end
         end else begin
            i_valid[kk] = remain[k] > 0;
            i_last[kk]  = last_all || remain[k] == 1;
         end
      end
      if (rand_mode) o_ready = $urandom_range(0, 3) != 0;
   endtask

   task automatic model_reset();
      m_vld = 1'b0; m_lock = 1'b0; m_start = 0; m_lock_id = 0;
      for (int k = 0; k < N; k++) sb[k].delete();
   endtask

   initial begin
      int exp_lock [5];
      int guard;
      rst = 1'b1; o_ready = 1'b1; i_valid = '0; i_last = '0;
      rand_mode = 1'b0; last_all = 1'b1; en_mask = '0;
      for (int k = 0; k < N; k++) begin
         i_data[2'(k)] = 64'(k) << 40;
         remain[k] = 0;
      end
      model_reset();
      @(posedge clk);
      #1;
      check("rst_o_valid", 64'(o_valid), 64'(0));
      check("rst_o_select", 64'(o_select), 64'(0));
      check("rst_o_last", 64'(o_last), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Input 0 sends a 3-beat packet while input 1 offers a 2-beat one.
      if (LOCK_EN) exp_lock = '{0, 0, 0, 1, 1};
      else         exp_lock = '{0, 1, 0, 1, 0};
      last_all = 1'b0; remain[0] = 3; remain[1] = 2; apply_src();
      out_sel.delete();
      guard = 0;
      while (out_sel.size() < 5 && guard < 50) begin tick(); guard++; end
      check("lock_beats", 64'(out_sel.size()), 64'(5));
      for (int i = 0; i < 5 && i < out_sel.size(); i++)
         check($sformatf("lock_sel%0d", i), 64'(out_sel[i]), 64'(exp_lock[i]));
      repeat (3) tick();

      // Reset mid-stream, then all-valid fairness.
      last_all = 1'b1;
      for (int k = 0; k < N; k++) remain[k] = 1000;
      apply_src();
      repeat (3) tick();
      check("pre_rst_o_valid", 64'(o_valid), 64'(1));
      rst = 1'b1;
      #1;
      check("midrst_o_valid", 64'(o_valid), 64'(0));
      check("midrst_o_select", 64'(o_select), 64'(0));
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_sel.delete(); out_cyc.delete();
      guard = 0;
      while (out_sel.size() < 8 && guard < 40) begin tick(); guard++; end
      check("fair_beats", 64'(out_sel.size()), 64'(8));
      for (int i = 0; i < 8 && i < out_sel.size(); i++) begin
         check($sformatf("fair_sel%0d", i), 64'(out_sel[i]), 64'(i % 4));
         if (i > 0) check("fair_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'(1));
      end
      for (int k = 0; k < N; k++) remain[k] = 0;
      apply_src();
      repeat (3) tick();

      // Single active source: six back-to-back beats 0x10..0x15.
      i_data[2] = 64'h10; remain[2] = 6; apply_src();
      out_sel.delete(); out_dat.delete(); out_cyc.delete(); acc2_cyc.delete();
      guard = 0;
      while (out_sel.size() < 6 && guard < 30) begin tick(); guard++; end
      check("ss_beats", 64'(out_sel.size()), 64'(6));
      for (int i = 0; i < 6 && i < out_sel.size(); i++) begin
         check("ss_sel", 64'(out_sel[i]), 64'(2));
         check("ss_data", out_dat[i], 64'h10 + 64'(i));
         if (i > 0) check("ss_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'(1));
      end
      if (out_cyc.size() > 0 && acc2_cyc.size() > 0)
         check("ss_latency", 64'(out_cyc[0] - acc2_cyc[0]), 64'(1));
      repeat (2) tick();

      // Backpressure: stall three cycles with a beat held.
      for (int k = 0; k < N; k++) remain[k] = 20;
      apply_src();
      repeat (2) tick();
      o_ready = 1'b0;
      repeat (3) begin
         tick();
         check("bp_data", o_data, last_acc_dat);
         check("bp_sel", 64'(o_select), 64'(last_acc_k));
         check("bp_rdy", 64'(i_ready), 64'(0));
      end
      o_ready = 1'b1;
      repeat (5) tick();
      for (int k = 0; k < N; k++) remain[k] = 0;
      apply_src();
      repeat (4) tick();
      for (int k = 0; k < N; k++) check("bp_sb_empty", 64'(sb[k].size()), 64'(0));

      // Random traffic on inputs 0..2.
      rand_mode = 1'b1; en_mask = 4'b0111;
      out_sel.delete();
      guard = 0;
      while (out_sel.size() < 1000 && guard < 20000) begin tick(); guard++; end
      check("rand_beats", 64'(out_sel.size() >= 1000), 64'(1));
      rand_mode = 1'b0; o_ready = 1'b1;
      for (int k = 0; k < N; k++) remain[k] = 0;
      apply_src();
      repeat (4) tick();
      for (int k = 0; k < N; k++) check("rand_sb_empty", 64'(sb[k].size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
